gb_cpu_bus_responder: RTL and testbench

//  Memory-side responder for the CPU address/data bus driven by the M-cycle control path.
//  - Serves CPU byte reads/writes directly for HRAM (0xFF80-0xFFFE) and the IE register (0xFFFF).
//  - Forwards every other address to an external memory port over a req/ack handshake,

---
 rtl/gb_cpu_bus_responder.sv | 141 ++++++++++++++
 tb/tb_gb_cpu_bus_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : gb_cpu_bus_responder
// Description : CPU bus responder serving HRAM and IE locally and forwarding
//               all other addresses to an external req/ack port with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_cpu_bus_responder #(
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [7:0] IE_RESET       = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic [4:0]  ie_o,
    output logic        bus_timeout
);

    localparam int             c_TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LOAD = c_TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_EXT_WAIT = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;

    logic [1:0]           r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [7:0]           r_rdata;
    logic                 r_ext_req;
    logic                 r_ext_we;
    logic [15:0]          r_ext_addr;
    logic [7:0]           r_ext_wdata;
    logic                 r_timeout;
    logic [7:0]           r_ie;

    // Entry 127 is never addressed: 0xFFFF decodes to IE instead.
    logic [7:0]           r_hram [0:127];

    logic w_ie_hit;
    logic w_hram_hit;
    logic w_idle_req;
    logic w_hram_we;

    assign w_ie_hit   = (cpu_addr == 16'hFFFF);
    assign w_hram_hit = (cpu_addr[15:7] == 9'h1FF) && !w_ie_hit;
    assign w_idle_req = (r_state == c_IDLE) && cpu_req;
    assign w_hram_we  = w_idle_req && cpu_we && w_hram_hit && !reset;

    always_ff @(posedge clk) begin
        if (w_hram_we) begin
            r_hram[cpu_addr[6:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_timer     <= '0;
            r_rdata     <= 8'h00;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= 16'h0000;
            r_ext_wdata <= 8'h00;
            r_timeout   <= 1'b0;
            r_ie        <= IE_RESET;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cpu_req) begin
                        if (w_ie_hit || w_hram_hit) begin
                            if (cpu_we) begin
                                if (w_ie_hit) begin
                                    r_ie <= cpu_wdata;
                                end
                            end else begin
                                r_rdata <= w_ie_hit ? r_ie : r_hram[cpu_addr[6:0]];
                            end
                            r_state <= c_DONE;
                        end else begin
                            r_ext_req   <= 1'b1;
                            r_ext_we    <= cpu_we;
                            r_ext_addr  <= cpu_addr;
                            r_ext_wdata <= cpu_wdata;
                            r_timer     <= c_TIMER_LOAD;
                            r_state     <= c_EXT_WAIT;
                        end
                    end
                end
                c_EXT_WAIT: begin
                    // An ack on the last permitted cycle still completes normally.
                    if (ext_ack) begin
                        r_ext_req <= 1'b0;
                        if (!r_ext_we) begin
                            r_rdata <= ext_rdata;
                        end
                        r_state <= c_DONE;
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_ext_req <= 1'b0;
                        if (!r_ext_we) begin
                            r_rdata <= 8'hFF;
                        end
                        r_timeout <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata   = r_rdata;
    assign cpu_ready   = (r_state == c_DONE);
    assign ext_req     = r_ext_req;
    assign ext_we      = r_ext_we;
    assign ext_addr    = r_ext_addr;
    assign ext_wdata   = r_ext_wdata;
    assign ie_o        = r_ie[4:0];
    assign bus_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_gb_cpu_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_cpu_bus_responder
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized transactions against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_cpu_bus_responder;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;
    logic [4:0]  ie_o;
    logic        bus_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    gb_cpu_bus_responder #(
        .TIMEOUT_CYCLES (c_TO),
        .IE_RESET       (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_ack     (ext_ack),
        .ext_rdata   (ext_rdata),
        .ie_o        (ie_o),
        .bus_timeout (bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          ack_dly;   // ext_req cycle on which ack is given; 0 = never
        logic [7:0]  ack_data;
        logic [7:0]  exp_rdata;
        logic        exp_to;
        int          exp_reqc;
        int          exp_lat;
        logic [4:0]  exp_ie;
    } vec_t;

    vec_t vecs [14];

    logic [7:0] m_hram [0:126];
    logic [7:0] m_ie;
    logic [7:0] m_rdata;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                             input int ack_dly, input logic [7:0] ack_data,
                             output logic [7:0] rdata, output logic to, output int reqc,
                             output int lat, output logic [15:0] xaddr, output logic xwe,
                             output logic [7:0] xwdata);
        reqc = 0; lat = -1; rdata = 8'h00; to = 1'b0;
        xaddr = 16'h0000; xwe = 1'b0; xwdata = 8'h00;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        for (int n = 1; n <= 40; n++) begin
            cycle();
            ext_ack = 1'b0;
            if (cpu_ready) begin
                lat = n; rdata = cpu_rdata; to = bus_timeout;
                break;
            end
            if (ext_req) begin
                reqc++;
                if (reqc == 1) begin
                    xaddr = ext_addr; xwe = ext_we; xwdata = ext_wdata;
                    // Scramble the CPU side: latched values must not follow.
                    cpu_addr = 16'($urandom); cpu_we = 1'($urandom); cpu_wdata = 8'($urandom);
                end
                if (reqc == ack_dly) begin
                    ext_ack = 1'b1; ext_rdata = ack_data;
                end else begin
                    ext_rdata = 8'($urandom);
                end
            end
        end
        cpu_req = 1'b0; ext_ack = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic we, input logic [15:0] addr,
                             input logic [7:0] wdata, input int ack_dly, input logic [7:0] ack_data,
                             input logic [7:0] exp_rdata, input logic exp_to,
                             input int exp_reqc, input int exp_lat);
        logic [7:0]  rdata;
        logic        to;
        int          reqc;
        int          lat;
        logic [15:0] xaddr;
        logic        xwe;
        logic [7:0]  xwdata;
        do_access(we, addr, wdata, ack_dly, ack_data, rdata, to, reqc, lat, xaddr, xwe, xwdata);
        check({tag, "_latency"}, lat, exp_lat);
        if (lat >= 0) begin
            check({tag, "_rdata"}, {24'h0, rdata}, {24'h0, exp_rdata});
            check({tag, "_timeout"}, {31'h0, to}, {31'h0, exp_to});
        end
        check({tag, "_ext_req_cycles"}, reqc, exp_reqc);
        if (exp_reqc > 0) begin
            check({tag, "_ext_addr"}, {16'h0, xaddr}, {16'h0, addr});
            check({tag, "_ext_we"}, {31'h0, xwe}, {31'h0, we});
            if (we) check({tag, "_ext_wdata"}, {24'h0, xwdata}, {24'h0, wdata});
        end
        cycle();
        check({tag, "_ready_one_cycle"}, {31'h0, cpu_ready}, 32'h0);
        check({tag, "_timeout_one_cycle"}, {31'h0, bus_timeout}, 32'h0);
    endtask

    initial begin
        logic [15:0] addr;
        logic [7:0]  wdata, ack_data, exp_rdata;
        logic        we, acked;
        int          dly, cls, idx;

        vecs[0]  = '{1'b1, 16'hFF80, 8'hA5, 0,  8'h00, 8'h00, 1'b0, 0,  1,  5'h00};
        vecs[1]  = '{1'b0, 16'hFF80, 8'h00, 0,  8'h00, 8'hA5, 1'b0, 0,  1,  5'h00};
        vecs[2]  = '{1'b1, 16'hFFFF, 8'h1F, 0,  8'h00, 8'hA5, 1'b0, 0,  1,  5'h1F};
        vecs[3]  = '{1'b0, 16'hFFFF, 8'h00, 0,  8'h00, 8'h1F, 1'b0, 0,  1,  5'h1F};
        vecs[4]  = '{1'b0, 16'hC000, 8'h00, 3,  8'h3C, 8'h3C, 1'b0, 3,  4,  5'h1F};
        vecs[5]  = '{1'b0, 16'h8000, 8'h00, 0,  8'h00, 8'hFF, 1'b1, 16, 17, 5'h1F};
        vecs[6]  = '{1'b0, 16'h8000, 8'h00, 16, 8'h77, 8'h77, 1'b0, 16, 17, 5'h1F};
        vecs[7]  = '{1'b1, 16'h4000, 8'h5A, 1,  8'hEE, 8'h77, 1'b0, 1,  2,  5'h1F};
        vecs[8]  = '{1'b1, 16'hFFFE, 8'h3C, 0,  8'h00, 8'h77, 1'b0, 0,  1,  5'h1F};
        vecs[9]  = '{1'b0, 16'hFFFE, 8'h00, 0,  8'h00, 8'h3C, 1'b0, 0,  1,  5'h1F};
        vecs[10] = '{1'b0, 16'hFF7F, 8'h00, 2,  8'h81, 8'h81, 1'b0, 2,  3,  5'h1F};
        vecs[11] = '{1'b0, 16'h0000, 8'h00, 17, 8'h99, 8'hFF, 1'b1, 16, 17, 5'h1F};
        vecs[12] = '{1'b1, 16'hFFFF, 8'hE2, 0,  8'h00, 8'hFF, 1'b0, 0,  1,  5'h02};
        vecs[13] = '{1'b0, 16'hFFFF, 8'h00, 0,  8'h00, 8'hE2, 1'b0, 0,  1,  5'h02};

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        ext_ack = 1'b0; ext_rdata = 8'h0;
        repeat (3) cycle();
        check("rst_cpu_rdata", {24'h0, cpu_rdata}, 32'h0);
        check("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
        check("rst_ext_req", {31'h0, ext_req}, 32'h0);
        check("rst_ext_we", {31'h0, ext_we}, 32'h0);
        check("rst_ext_addr", {16'h0, ext_addr}, 32'h0);
        check("rst_ext_wdata", {24'h0, ext_wdata}, 32'h0);
        check("rst_bus_timeout", {31'h0, bus_timeout}, 32'h0);
        check("rst_ie_o", {27'h0, ie_o}, 32'h0);
        reset = 1'b0;
        cycle();

        for (int i = 0; i < 14; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].ack_dly, vecs[i].ack_data, vecs[i].exp_rdata, vecs[i].exp_to,
                      vecs[i].exp_reqc, vecs[i].exp_lat);
            check($sformatf("vec%0d_ie_o", i), {27'h0, ie_o}, {27'h0, vecs[i].exp_ie});
        end

        // Ack with no transfer in flight must do nothing.
        ext_ack = 1'b1; ext_rdata = 8'h55;
        cycle();
        check("spurious_ready", {31'h0, cpu_ready}, 32'h0);
        check("spurious_ext_req", {31'h0, ext_req}, 32'h0);
        ext_ack = 1'b0;
        cycle();
        check("spurious_rdata", {24'h0, cpu_rdata}, 32'hE2);

        // Request held through DONE: consumed there, re-sampled in the following IDLE.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF80;
        cycle();
        check("hold_ready_1", {31'h0, cpu_ready}, 32'h1);
        check("hold_rdata", {24'h0, cpu_rdata}, 32'hA5);
        cycle();
        check("hold_ready_2", {31'h0, cpu_ready}, 32'h0);
        cycle();
        check("hold_ready_3", {31'h0, cpu_ready}, 32'h1);
        cpu_req = 1'b0;
        cycle();
        check("hold_ready_4", {31'h0, cpu_ready}, 32'h0);

        // Asynchronous reset in the middle of an external wait.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
        repeat (5) cycle();
        check("midrst_pre_ext_req", {31'h0, ext_req}, 32'h1);
        #3 reset = 1'b1;
        #1;
        check("midrst_ext_req", {31'h0, ext_req}, 32'h0);
        check("midrst_ready", {31'h0, cpu_ready}, 32'h0);
        check("midrst_ie_o", {27'h0, ie_o}, 32'h0);
        check("midrst_rdata", {24'h0, cpu_rdata}, 32'h0);
        cpu_req = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        run_check("midrst_hram", 1'b0, 16'hFFFE, 8'h00, 0, 8'h00, 8'h3C, 1'b0, 0, 1);

        // Randomized phase against the transaction-level model.
        m_rdata = 8'h3C;
        m_ie    = 8'h00;
        for (int i = 0; i < 127; i++) begin
            wdata = 8'($urandom);
            run_check("init", 1'b1, 16'hFF80 + 16'(i), wdata, 0, 8'h00, m_rdata, 1'b0, 0, 1);
            m_hram[i] = wdata;
        end
        for (int t = 0; t < 300; t++) begin
            cls      = int'($urandom_range(0, 3));
            we       = 1'($urandom_range(0, 1));
            wdata    = 8'($urandom);
            ack_data = 8'($urandom);
            dly      = int'($urandom_range(0, c_TO + 2));
            if (cls <= 1)      addr = 16'hFF80 + 16'($urandom_range(0, 126));
            else if (cls == 2) addr = 16'hFFFF;
            else               addr = 16'($urandom_range(0, 32'hFF7F));
            if (addr >= 16'hFF80) begin
                idx = int'(addr) - 32'hFF80;
                if (we) begin
                    if (addr == 16'hFFFF) m_ie = wdata;
                    else                  m_hram[idx] = wdata;
                    exp_rdata = m_rdata;
                end else begin
                    exp_rdata = (addr == 16'hFFFF) ? m_ie : m_hram[idx];
                end
                m_rdata = exp_rdata;
                run_check("rnd_int", we, addr, wdata, dly, ack_data, exp_rdata, 1'b0, 0, 1);
            end else begin
                acked     = (dly >= 1) && (dly <= c_TO);
                exp_rdata = we ? m_rdata : (acked ? ack_data : 8'hFF);
                m_rdata   = exp_rdata;
                run_check("rnd_ext", we, addr, wdata, dly, ack_data, exp_rdata, !acked,
                          acked ? dly : c_TO, acked ? dly + 1 : c_TO + 1);
            end
            check("rnd_ie_o", {27'h0, ie_o}, {27'h0, m_ie[4:0]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
